// File: rtl/opb_master_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : opb_master_arb_if
//  Description : Bundles the two requester channels and the shared OPB master
//                signals of opb_master_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
interface opb_master_arb_if;
   // requester side
   logic        m0_req;
   logic        m1_req;
   logic        m0_we;
   logic        m1_we;
   logic [31:0] m0_addr;
   logic [31:0] m1_addr;
   logic [31:0] m0_do;
   logic [31:0] m1_do;
   logic        m0_gnt;
   logic        m1_gnt;
   logic        m0_done;
   logic        m1_done;
   logic        m0_err;
   logic        m1_err;
   logic [31:0] m0_di;
   logic [31:0] m1_di;
   // OPB side
   logic [31:0] opb_addr;
   logic [31:0] opb_do;
   logic [31:0] opb_di;
   logic        opb_we;
   logic        opb_re;
   logic        opb_ack;
   logic        busy;

   // arbiter view
   modport master (
      input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_do, m1_do,
      input  opb_di, opb_ack,
      output m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, m0_di, m1_di,
      output opb_addr, opb_do, opb_we, opb_re, busy
   );

   // requesters + slave view
   modport slave (
      output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_do, m1_do,
      output opb_di, opb_ack,
      input  m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, m0_di, m1_di,
      input  opb_addr, opb_do, opb_we, opb_re, busy
   );
endinterface
`default_nettype wire

// File: rtl/opb_master_arb.sv
`default_nettype none
// ============================================================================
//  Module      : opb_master_arb
//  Description : Round-robin arbiter sharing one OPB master port between two
//                requesters; one transfer at a time, ACK wait bounded by a
//                timeout counted in PULSE_2KHZ rising edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module opb_master_arb #(
   parameter int unsigned TIMEOUT_TICKS = 200   // 1..65535
) (
   input  logic             opb_clk,
   input  logic             opb_rst_n,
   input  logic             pulse_2khz,
   opb_master_arb_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT_TICKS);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_last_grant;   // 1 = M1 owned the previous transfer
   logic        r_owner;        // 1 = M1 owns the current transfer
   logic        r_pulse_d;
   logic [15:0] r_tick_cnt;
   logic [15:0] w_tick_cnt_nxt;
   logic        w_pulse_rise;
   logic        w_grant;
   logic        w_grant_m1;
   logic        w_ack;
   logic        w_timeout;
   logic        w_sel_we;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_do;

   // Next-state, arbitration and timeout decode
   always_comb begin
      w_state_nxt    = r_state;
      w_grant        = 1'b0;
      w_grant_m1     = 1'b0;
      w_ack          = 1'b0;
      w_timeout      = 1'b0;
      w_pulse_rise   = pulse_2khz & ~r_pulse_d;
      w_tick_cnt_nxt = r_tick_cnt;
      if (w_pulse_rise && (r_tick_cnt != C_TIMEOUT)) begin
         w_tick_cnt_nxt = r_tick_cnt + 16'd1;
      end
      case (r_state)
         ST_IDLE: begin
            if (bus.m0_req || bus.m1_req) begin
               w_grant     = 1'b1;
               // M1 wins when alone, or when both ask and M0 went last
               w_grant_m1  = bus.m1_req && (!bus.m0_req || !r_last_grant);
               w_state_nxt = ST_XFER;
            end
         end
         ST_XFER: begin
            // the edge that reaches the limit already times out; ACK wins a tie
            w_ack     = bus.opb_ack;
            w_timeout = !bus.opb_ack && (w_tick_cnt_nxt == C_TIMEOUT);
            if (w_ack || w_timeout) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_sel_we   = w_grant_m1 ? bus.m1_we   : bus.m0_we;
   assign w_sel_addr = w_grant_m1 ? bus.m1_addr : bus.m0_addr;
   assign w_sel_do   = w_grant_m1 ? bus.m1_do   : bus.m0_do;

   // State register
   always_ff @(posedge opb_clk or negedge opb_rst_n) begin
      if (!opb_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Registered bus strobes, grants, completion status and read data
   always_ff @(posedge opb_clk or negedge opb_rst_n) begin
      if (!opb_rst_n) begin
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_pulse_d    <= 1'b0;
         r_tick_cnt   <= 16'd0;
         bus.m0_gnt   <= 1'b0;
         bus.m1_gnt   <= 1'b0;
         bus.m0_done  <= 1'b0;
         bus.m1_done  <= 1'b0;
         bus.m0_err   <= 1'b0;
         bus.m1_err   <= 1'b0;
         bus.m0_di    <= 32'd0;
         bus.m1_di    <= 32'd0;
         bus.opb_addr <= 32'd0;
         bus.opb_do   <= 32'd0;
         bus.opb_we   <= 1'b0;
         bus.opb_re   <= 1'b0;
         bus.busy     <= 1'b0;
      end else begin
         r_pulse_d   <= pulse_2khz;
         bus.m0_done <= 1'b0;
         bus.m1_done <= 1'b0;
         bus.m0_err  <= 1'b0;
         bus.m1_err  <= 1'b0;
         bus.busy    <= (w_state_nxt != ST_IDLE);

         if (w_grant) begin
            r_owner      <= w_grant_m1;
            r_last_grant <= w_grant_m1;
            r_tick_cnt   <= 16'd0;
            bus.m0_gnt   <= !w_grant_m1;
            bus.m1_gnt   <= w_grant_m1;
            bus.opb_we   <= w_sel_we;
            bus.opb_re   <= !w_sel_we;
            bus.opb_addr <= w_sel_addr;
            bus.opb_do   <= w_sel_do;
         end

         if (r_state == ST_XFER) begin
            r_tick_cnt <= w_tick_cnt_nxt;
            if (w_ack || w_timeout) begin
               bus.opb_we <= 1'b0;
               bus.opb_re <= 1'b0;
               if (r_owner) begin
                  bus.m1_done <= 1'b1;
                  bus.m1_err  <= w_timeout;
                  if (bus.opb_re) begin
                     bus.m1_di <= w_ack ? bus.opb_di : 32'hFFFF_FFFF;
                  end
               end else begin
                  bus.m0_done <= 1'b1;
                  bus.m0_err  <= w_timeout;
                  if (bus.opb_re) begin
                     bus.m0_di <= w_ack ? bus.opb_di : 32'hFFFF_FFFF;
                  end
               end
            end
         end

         if (r_state == ST_DONE) begin
            bus.m0_gnt <= 1'b0;
            bus.m1_gnt <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_opb_master_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_opb_master_arb
//  Description : Directed self-checking bench for opb_master_arb.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_opb_master_arb;

   logic opb_clk    = 1'b0;
   logic opb_rst_n  = 1'b0;
   logic pulse_2khz = 1'b0;
   int   checks     = 0;
   int   failures   = 0;
   logic early;
   logic seen;

   opb_master_arb_if bus ();

   opb_master_arb #(.TIMEOUT_TICKS(200)) dut (
      .opb_clk    (opb_clk),
      .opb_rst_n  (opb_rst_n),
      .pulse_2khz (pulse_2khz),
      .bus        (bus)
   );

   always #5 opb_clk = ~opb_clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge opb_clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.m0_req = 1'b0; bus.m1_req = 1'b0;
      bus.m0_we  = 1'b0; bus.m1_we  = 1'b0;
      bus.m0_addr = 32'd0; bus.m1_addr = 32'd0;
      bus.m0_do   = 32'd0; bus.m1_do   = 32'd0;
      bus.opb_di  = 32'd0; bus.opb_ack = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      opb_rst_n = 1'b0;
      tick(2);
      opb_rst_n = 1'b1;
   endtask

   // 200 single-cycle pulses, 50 ns period; optional ACK on the last edge
   task automatic pulse_train(input bit ack_last, output logic early_done);
      early_done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         pulse_2khz = 1'b1;
         if (ack_last && i == 199) begin
            bus.opb_ack = 1'b1;
            bus.opb_di  = 32'hCAFE_F00D;
         end
         tick();
         pulse_2khz  = 1'b0;
         bus.opb_ack = 1'b0;
         if (i < 199) begin
            early_done |= bus.m0_done;
            repeat (4) begin
               tick();
               early_done |= bus.m0_done;
            end
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      tick(2);
      // reset state
      chk1("rst_m0_gnt", bus.m0_gnt, 1'b0);
      chk1("rst_m1_gnt", bus.m1_gnt, 1'b0);
      chk1("rst_re", bus.opb_re, 1'b0);
      chk1("rst_we", bus.opb_we, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk32("rst_addr", bus.opb_addr, 32'd0);
      chk32("rst_m0_di", bus.m0_di, 32'd0);
      opb_rst_n = 1'b1;

      // single M0 read, ACK two cycles after the strobe
      bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h1234_5678;
      tick();
      chk1("t1_c1_gnt", bus.m0_gnt, 1'b1);
      chk1("t1_c1_re", bus.opb_re, 1'b1);
      chk1("t1_c1_we", bus.opb_we, 1'b0);
      chk32("t1_addr", bus.opb_addr, 32'h1234_5678);
      chk1("t1_busy", bus.busy, 1'b1);
      tick();
      chk1("t1_c2_re", bus.opb_re, 1'b1);
      tick();
      chk1("t1_c3_re", bus.opb_re, 1'b1);
      bus.opb_ack = 1'b1; bus.opb_di = 32'hAABB_CCDD;
      tick();
      bus.opb_ack = 1'b0; bus.opb_di = 32'd0;
      chk1("t1_c4_re", bus.opb_re, 1'b0);
      chk1("t1_c4_gnt", bus.m0_gnt, 1'b1);
      chk1("t1_done", bus.m0_done, 1'b1);
      chk1("t1_err", bus.m0_err, 1'b0);
      chk32("t1_di", bus.m0_di, 32'hAABB_CCDD);
      chk1("t1_m1_gnt", bus.m1_gnt, 1'b0);
      chk1("t1_m1_done", bus.m1_done, 1'b0);
      chk32("t1_m1_di", bus.m1_di, 32'd0);
      bus.m0_req = 1'b0;
      tick();
      chk1("t1_c5_done", bus.m0_done, 1'b0);
      chk1("t1_c5_gnt", bus.m0_gnt, 1'b0);
      chk1("t1_c5_busy", bus.busy, 1'b0);

      // simultaneous pair after reset: M0 write first, then M1 read
      do_reset();
      bus.m0_req = 1'b1; bus.m0_we = 1'b1;
      bus.m0_addr = 32'hAABB_CCDD; bus.m0_do = 32'h1122_3344;
      bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h1234_5678;
      tick();
      chk1("p1_m0_gnt", bus.m0_gnt, 1'b1);
      chk1("p1_m1_gnt", bus.m1_gnt, 1'b0);
      chk1("p1_we", bus.opb_we, 1'b1);
      chk1("p1_re", bus.opb_re, 1'b0);
      chk32("p1_addr", bus.opb_addr, 32'hAABB_CCDD);
      chk32("p1_do", bus.opb_do, 32'h1122_3344);
      bus.opb_ack = 1'b1;
      tick();
      bus.opb_ack = 1'b0;
      chk1("p1_m0_done", bus.m0_done, 1'b1);
      chk1("p1_we_drop", bus.opb_we, 1'b0);
      chk32("p1_m0_di_write", bus.m0_di, 32'd0);
      bus.m0_req = 1'b0;
      tick();
      chk1("p1_idle_m1_gnt", bus.m1_gnt, 1'b0);
      chk1("p1_idle_busy", bus.busy, 1'b0);
      tick();
      chk1("p1_m1_gnt", bus.m1_gnt, 1'b1);
      chk1("p1_m1_re", bus.opb_re, 1'b1);
      chk32("p1_m1_addr", bus.opb_addr, 32'h1234_5678);
      bus.opb_ack = 1'b1; bus.opb_di = 32'h5566_7788;
      tick();
      bus.opb_ack = 1'b0;
      chk1("p1_m1_done", bus.m1_done, 1'b1);
      chk1("p1_m1_err", bus.m1_err, 1'b0);
      chk32("p1_m1_di", bus.m1_di, 32'h5566_7788);
      bus.m1_req = 1'b0;
      tick();

      // M1 requests continuously, M0 arrives during M1's transfer
      bus.m1_req = 1'b1; bus.m1_addr = 32'h0000_0100;
      tick();
      chk1("rr_m1_first", bus.m1_gnt, 1'b1);
      bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h0000_0200;
      bus.opb_ack = 1'b1; bus.opb_di = 32'h0000_0001;
      tick();
      bus.opb_ack = 1'b0;
      chk1("rr_m1_done", bus.m1_done, 1'b1);
      tick(2);
      chk1("rr_m0_next", bus.m0_gnt, 1'b1);
      chk1("rr_m1_not_again", bus.m1_gnt, 1'b0);
      chk32("rr_m0_addr", bus.opb_addr, 32'h0000_0200);
      bus.m1_req = 1'b0;
      bus.opb_ack = 1'b1; bus.opb_di = 32'h0000_0002;
      tick();
      bus.opb_ack = 1'b0;
      chk1("rr_m0_done", bus.m0_done, 1'b1);
      chk32("rr_m0_di", bus.m0_di, 32'h0000_0002);
      bus.m0_req = 1'b0;
      tick();

      // second simultaneous pair, M0 went last so M1 goes first
      bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_0300;
      bus.m1_req = 1'b1; bus.m1_addr = 32'h0000_0400;
      tick();
      chk1("p2_m1_gnt", bus.m1_gnt, 1'b1);
      chk1("p2_m0_wait", bus.m0_gnt, 1'b0);
      chk32("p2_addr", bus.opb_addr, 32'h0000_0400);
      bus.opb_ack = 1'b1; bus.opb_di = 32'h0000_0004;
      tick();
      bus.opb_ack = 1'b0;
      chk1("p2_m1_done", bus.m1_done, 1'b1);
      bus.m1_req = 1'b0;
      tick(2);
      chk1("p2_m0_gnt", bus.m0_gnt, 1'b1);
      chk32("p2_m0_addr", bus.opb_addr, 32'h0000_0300);
      bus.opb_ack = 1'b1; bus.opb_di = 32'h0000_0003;
      tick();
      bus.opb_ack = 1'b0;
      chk1("p2_m0_done", bus.m0_done, 1'b1);
      chk32("p2_m0_di", bus.m0_di, 32'h0000_0003);
      bus.m0_req = 1'b0;
      tick();

      // slave never ACKs: timeout after 200 pulse edges
      bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_0500;
      tick();
      chk1("to_gnt", bus.m0_gnt, 1'b1);
      pulse_train(1'b0, early);
      chk1("to_no_early_done", early, 1'b0);
      chk1("to_done", bus.m0_done, 1'b1);
      chk1("to_err", bus.m0_err, 1'b1);
      chk32("to_di", bus.m0_di, 32'hFFFF_FFFF);
      chk1("to_re_drop", bus.opb_re, 1'b0);
      bus.m0_req = 1'b0;
      tick();

      // next request after a timeout completes normally
      bus.m1_req = 1'b1; bus.m1_addr = 32'h0000_0600;
      tick();
      chk1("post_to_gnt", bus.m1_gnt, 1'b1);
      bus.opb_ack = 1'b1; bus.opb_di = 32'h0000_0066;
      tick();
      bus.opb_ack = 1'b0;
      chk1("post_to_done", bus.m1_done, 1'b1);
      chk1("post_to_err", bus.m1_err, 1'b0);
      chk32("post_to_di", bus.m1_di, 32'h0000_0066);
      bus.m1_req = 1'b0;
      tick();

      // ACK on the same cycle as the 200th pulse edge
      bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_0700;
      tick();
      pulse_train(1'b1, early);
      chk1("tie_no_early_done", early, 1'b0);
      chk1("tie_done", bus.m0_done, 1'b1);
      chk1("tie_err", bus.m0_err, 1'b0);
      chk32("tie_di", bus.m0_di, 32'hCAFE_F00D);
      bus.m0_req = 1'b0;
      tick();

      // reset in the middle of a transfer
      bus.m1_req = 1'b1; bus.m1_addr = 32'h0000_0800;
      tick();
      chk1("mrst_gnt_before", bus.m1_gnt, 1'b1);
      chk1("mrst_re_before", bus.opb_re, 1'b1);
      bus.m0_req = 1'b1; bus.m0_addr = 32'h0000_0900;
      #2;
      opb_rst_n = 1'b0;
      #1;
      chk1("mrst_re_async", bus.opb_re, 1'b0);
      chk1("mrst_gnt_async", bus.m1_gnt, 1'b0);
      chk32("mrst_m1_di_clr", bus.m1_di, 32'd0);
      seen = 1'b0;
      repeat (3) begin
         tick();
         seen |= bus.m1_done | bus.m0_done;
      end
      chk1("mrst_no_done", seen, 1'b0);
      opb_rst_n = 1'b1;
      tick();
      chk1("mrst_m0_wins", bus.m0_gnt, 1'b1);
      chk1("mrst_m1_waits", bus.m1_gnt, 1'b0);
      chk32("mrst_addr", bus.opb_addr, 32'h0000_0900);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
